glb_bank_sram_array: RTL
========================

Name: glb_bank_sram_array

Overview:
Parametrised successor to the global-buffer bank SRAM generator. It tiles SRAM macros in two dimensions: depth as rows of macros, width as columns of macros. It supports non-power-of-two depth, flags out-of-range addresses, and provides a read-valid strobe with hold-last-data output. The block sits between the GLB bank controller and the physical macros, and has a fixed, documented read latency.

Parameters:
DATA_WIDTH, 64, logical word width in bits.
ADDR_WIDTH, 14, logical address width.
NUM_WORDS, 16384, logical depth; must be <= 2^ADDR_WIDTH and need not be a power of two.
MACRO_ADDR_WIDTH, 11, address width of one macro (macro depth 2^MACRO_ADDR_WIDTH).
MACRO_DATA_WIDTH, 64, data width of one macro.
Derived values:
- NUM_ROW = ceil(NUM_WORDS / 2^MACRO_ADDR_WIDTH)
- NUM_COL = ceil(DATA_WIDTH / MACRO_DATA_WIDTH)
- ROW_SEL_W = max(1, ADDR_WIDTH - MACRO_ADDR_WIDTH)

Ports:
CLK  input  1  clock
reset  input  1  asynchronous, active-high reset
CEB  input  1  chip enable, active low
WEB  input  1  write enable, active low; meaningful only when CEB=0
BWEB  input  DATA_WIDTH  per-bit write mask, active low
A  input  ADDR_WIDTH  word address
D  input  DATA_WIDTH  write data
Q  output  DATA_WIDTH  read data; holds the last valid read
Q_valid  output  1  one-cycle strobe; Q carries new read data
addr_err  output  1  one-cycle strobe; the registered request had A >= NUM_WORDS

Behaviour:
- Reset values:
  - Q=0, Q_valid=0, addr_err=0.
  - All pipeline CEB/WEB registers = 1 (idle).
  - BWEB register = all 1s; D and address registers = 0.
  - Row-select tracking register = 0.
- Stage 0 (input register), at the CLK edge after a request:
  - Register CEB, WEB, BWEB, D, A.
  - Decode row = A[ADDR_WIDTH-1:MACRO_ADDR_WIDTH].
  - Macro-local address = A[MACRO_ADDR_WIDTH-1:0].
- Stage 1 (macro access):
  - Only the macros in row `row` see CEB=0; all NUM_COL macros in that row share the address and enable.
  - Column c receives D/BWEB bits [c*MACRO_DATA_WIDTH +: MACRO_DATA_WIDTH].
  - Bits beyond DATA_WIDTH in the last column are padded with D=0 and BWEB=1 (never written).
  - Macros have a 1-cycle read latency.
- Read latency: request at edge N gives Q updated and Q_valid=1 in the cycle after edge N+2 (latency 2).
- Output select:
  - The registered row for a read is carried alongside the macro access and muxes that row's columns onto Q.
  - Columns are concatenated and truncated to DATA_WIDTH.
- Writes never produce Q_valid and never change Q.
- When no read completes, Q holds its previous value (it is registered, not a pass-through of the macro Q).
- Out-of-range request (A >= NUM_WORDS, including a row index >= NUM_ROW):
  - No macro is enabled.
  - addr_err pulses at the same cycle Q_valid would.
  - For a read: Q_valid=1 and Q is forced to 0.
  - For a write: no memory change.
- Back-to-back requests:
  - One request per cycle is accepted with no stalls.
  - Read-after-write to the same address on consecutive cycles returns the new data; the macros guarantee this because the write completes before the read samples.
- Simultaneous CEB=0 with reset asserted: reset wins; the request is dropped.
- Reset asserted mid-operation:
  - In-flight reads are discarded; no Q_valid is emitted after reset deassertion.
  - Memory contents are undefined/unchanged; reset does not clear the SRAM.
- BWEB: bit i written only when BWEB[i]=0; a fully-masked write is a legal no-op.

Optional Feature:
GLB_SRAM_OUT_REG_EN
- Defined: an extra register stage follows the output mux. Q, Q_valid and addr_err all shift one cycle later (read latency 3); this is used for timing closure on wide arrays. Reset values are unchanged.
- Undefined: read latency is 2, as specified above.
- The bench reads a LATENCY localparam derived from the macro, so all checks are latency-agnostic.

Test Plan:
1. Default params. Write D=64'hDEAD_BEEF_0123_4567 to A=0x0000 and 64'h1 to A=0x3FFF, then read both. Expect Q_valid pulses exactly 2 cycles after each read with the matching data, and addr_err=0.
2. Set DATA_WIDTH=80, MACRO_DATA_WIDTH=64 (NUM_COL=2).
   - Write 80'hFFFF_0000_0000_0000_ABCD to A=5, then rewrite with BWEB=~80'hFFFF (only low 16 bits written) and D=0.
   - Read A=5: expect 80'hFFFF_0000_0000_0000_0000.
3. Set NUM_WORDS=5000 (NUM_ROW=3).
   - Read A=4999: expect valid data, addr_err=0.
   - Read A=5000: expect Q_valid=1, Q=0, addr_err=1, and no macro CEB low.
   - Write to A=6000, then read A=6000: no macro enabled, addr_err=1.
4. Issue back-to-back reads to A=0x0800 (row 1), A=0x1000 (row 2), A=0x0001 (row 0) on consecutive cycles. Expect three consecutive Q_valid cycles, each with its own row's data in order.
5. Issue a read at A=0x10, then write A=0x20 and idle 5 cycles. Q must hold the A=0x10 data, with Q_valid high only once.
6. Issue a read and assert reset 1 cycle later for 2 cycles. Expect no Q_valid at any point; Q=0 after reset. Repeat with GLB_SRAM_OUT_REG_EN defined and check latency 3 in scenario 1.

Source files
------------

// File: rtl/glb_bank_sram_array.sv
//------------------------------------------------------------------------------
// glb_bank_sram_array
//   Global-buffer bank SRAM built from a 2-D tiling of single-port macros:
//   NUM_ROW rows of macros cover the logical depth, and NUM_COL columns of
//   macros cover the logical word width. The depth does not have to be a power
//   of two. Requests with A >= NUM_WORDS enable no macro and raise addr_err.
//
//   Pipeline: stage 0 registers the request, stage 1 is the macro access
//   (1-cycle macro read), stage 2 registers the row-muxed read data.
//   The read latency is 2. If GLB_SRAM_OUT_REG_EN is defined, an extra output
//   register is added and the read latency becomes 3.
//
// Ports
//   CLK      clock
//   reset    asynchronous reset, active high
//   CEB      chip enable, active low
//   WEB      write enable, active low (only used when CEB=0)
//   BWEB     per-bit write mask, active low
//   A        word address
//   D        write data
//   Q        read data; holds the last valid read
//   Q_valid  one-cycle strobe that marks new read data on Q
//   addr_err one-cycle strobe; the request had A >= NUM_WORDS
//------------------------------------------------------------------------------
`timescale 1ns/1ps

// Behavioural single-port macro: 1-cycle read, bit-masked write, no reset.
module glb_bank_sram_macro #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  CLK,
  input  logic                  CEB,
  input  logic                  WEB,
  input  logic [DATA_WIDTH-1:0] BWEB,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge CLK) begin
    if (!CEB) begin
      if (!WEB) begin
        mem[A] <= (mem[A] & BWEB) | (D & ~BWEB);
      end else begin
        Q <= mem[A];
      end
    end
  end

endmodule

module glb_bank_sram_array #(
  parameter int DATA_WIDTH       = 64,
  parameter int ADDR_WIDTH       = 14,
  parameter int NUM_WORDS        = 16384,
  parameter int MACRO_ADDR_WIDTH = 11,
  parameter int MACRO_DATA_WIDTH = 64
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  CEB,
  input  logic                  WEB,
  input  logic [DATA_WIDTH-1:0] BWEB,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  Q_valid,
  output logic                  addr_err
);

  localparam int MACRO_DEPTH = 2**MACRO_ADDR_WIDTH;
  localparam int NUM_ROW     = (NUM_WORDS + MACRO_DEPTH - 1) / MACRO_DEPTH;
  localparam int NUM_COL     = (DATA_WIDTH + MACRO_DATA_WIDTH - 1) / MACRO_DATA_WIDTH;
  localparam int PAD_W       = NUM_COL * MACRO_DATA_WIDTH;
  localparam int ROW_SEL_W   = (ADDR_WIDTH > MACRO_ADDR_WIDTH) ?
                               (ADDR_WIDTH - MACRO_ADDR_WIDTH) : 1;
  localparam logic [ADDR_WIDTH:0] WORDS_LIMIT = (ADDR_WIDTH+1)'(NUM_WORDS);

  // Stage 0: registered request
  logic                  s0_ceb;
  logic                  s0_web;
  logic [DATA_WIDTH-1:0] s0_bweb;
  logic [DATA_WIDTH-1:0] s0_d;
  logic [ADDR_WIDTH-1:0] s0_a;
  logic [ROW_SEL_W-1:0]  s0_row;
  logic                  s0_err;

  // Stage 1: bookkeeping carried alongside the macro access
  logic                  s1_ceb;
  logic                  s1_web;
  logic                  s1_err;
  logic [ROW_SEL_W-1:0]  s1_row;

  // Stage 2: registered mux output
  logic [DATA_WIDTH-1:0] q2;
  logic                  v2;
  logic                  e2;

  logic [NUM_ROW-1:0]          row_ceb;
  logic [PAD_W-1:0]            d_pad;
  logic [PAD_W-1:0]            bweb_pad;
  logic [PAD_W-1:0]            row_q;
  logic [MACRO_DATA_WIDTH-1:0] macro_q [NUM_ROW][NUM_COL];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      s0_ceb  <= 1'b1;
      s0_web  <= 1'b1;
      s0_bweb <= '1;
      s0_d    <= '0;
      s0_a    <= '0;
    end else begin
      s0_ceb  <= CEB;
      s0_web  <= WEB;
      s0_bweb <= BWEB;
      s0_d    <= D;
      s0_a    <= A;
    end
  end

  if (ADDR_WIDTH > MACRO_ADDR_WIDTH) begin : g_row_dec
    assign s0_row = s0_a[ADDR_WIDTH-1:MACRO_ADDR_WIDTH];
  end else begin : g_row_one
    assign s0_row = '0;
  end

  // Any row index >= NUM_ROW also implies A >= NUM_WORDS, so this one
  // compare covers both out-of-range cases.
  assign s0_err = ({1'b0, s0_a} >= WORDS_LIMIT);

  always_comb begin
    row_ceb = '1;
    for (int unsigned r = 0; r < NUM_ROW; r++) begin
      row_ceb[r] = s0_ceb | s0_err | (s0_row != ROW_SEL_W'(r));
    end
  end

  // Padding bits in the last column are never written.
  always_comb begin
    d_pad                     = '0;
    d_pad[DATA_WIDTH-1:0]     = s0_d;
    bweb_pad                  = '1;
    bweb_pad[DATA_WIDTH-1:0]  = s0_bweb;
  end

  for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
      glb_bank_sram_macro #(
        .ADDR_WIDTH (MACRO_ADDR_WIDTH),
        .DATA_WIDTH (MACRO_DATA_WIDTH)
      ) u_macro (
        .CLK  (CLK),
        .CEB  (row_ceb[r]),
        .WEB  (s0_web),
        .BWEB (bweb_pad[c*MACRO_DATA_WIDTH +: MACRO_DATA_WIDTH]),
        .A    (s0_a[MACRO_ADDR_WIDTH-1:0]),
        .D    (d_pad[c*MACRO_DATA_WIDTH +: MACRO_DATA_WIDTH]),
        .Q    (macro_q[r][c])
      );
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      s1_ceb <= 1'b1;
      s1_web <= 1'b1;
      s1_err <= 1'b0;
      s1_row <= '0;
    end else begin
      s1_ceb <= s0_ceb;
      s1_web <= s0_web;
      s1_err <= s0_err;
      s1_row <= s0_row;
    end
  end

  always_comb begin
    row_q = '0;
    for (int unsigned r = 0; r < NUM_ROW; r++) begin
      if (s1_row == ROW_SEL_W'(r)) begin
        for (int unsigned c = 0; c < NUM_COL; c++) begin
          row_q[c*MACRO_DATA_WIDTH +: MACRO_DATA_WIDTH] = macro_q[r][c];
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      q2 <= '0;
      v2 <= 1'b0;
      e2 <= 1'b0;
    end else begin
      v2 <= ~s1_ceb & s1_web;
      e2 <= ~s1_ceb & s1_err;
      if (~s1_ceb & s1_web) begin
        q2 <= s1_err ? '0 : row_q[DATA_WIDTH-1:0];
      end
    end
  end

`ifdef GLB_SRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] q3;
  logic                  v3;
  logic                  e3;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      q3 <= '0;
      v3 <= 1'b0;
      e3 <= 1'b0;
    end else begin
      v3 <= v2;
      e3 <= e2;
      if (v2) begin
        q3 <= q2;
      end
    end
  end

  assign Q        = q3;
  assign Q_valid  = v3;
  assign addr_err = e3;
`else
  assign Q        = q2;
  assign Q_valid  = v2;
  assign addr_err = e2;
`endif

endmodule
